gray_updown_counter: RTL
========================

Name: gray_updown_counter

Overview:
Parametrised successor to the team's Gray up counter. Counts up or down, supports synchronous binary load, and offers a selectable wrap or saturate mode. Provides registered Gray, next-Gray and binary outputs plus terminal-count and wrap flags. Used for async-FIFO pointers needing rewind/preset, and for bidirectional position counters crossing clock domains.

Parameters:
WIDTH, 8, counter width in bits (>= 2)
RESET_VAL, 0, binary value loaded on reset (0 .. 2**WIDTH-1)
SATURATE, 0, 0 = wrap modulo 2**WIDTH; 1 = hold at terminal value

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, asynchronous, active-high
en_i  input  1  count enable, one step per enabled cycle
dir_i  input  1  direction sampled with en_i/load_i: 1 = up, 0 = down
load_i  input  1  synchronous load, has priority over en_i
load_val_i  input  WIDTH  binary value to load
count_o  output  WIDTH  current count, Gray coded, registered
nextCount_o  output  WIDTH  Gray code of the next count in the latched direction, registered
binCount_o  output  WIDTH  current count, binary, registered
tc_o  output  1  terminal count: count is 2**WIDTH-1 while latched direction is up, or 0 while it is down
wrap_o  output  1  one-cycle pulse; the last step wrapped

Behaviour:
- Internal state: bin_r[WIDTH], dir_r. Every output is a register or a pure function of registers; there is no combinational input-to-output path. Latency from any input to any output is one clock.
- Reset (async, on rst_i high):
  - bin_r = RESET_VAL, dir_r = 1
  - count_o = gray(RESET_VAL)
  - nextCount_o = gray((RESET_VAL+1) mod 2**WIDTH); equals count_o if SATURATE=1 and RESET_VAL = max
  - binCount_o = RESET_VAL
  - tc_o = (RESET_VAL == max), wrap_o = 0
- Deassertion is sampled by clk_i. The first count is allowed on the first edge after release.
- Priority per edge: rst_i > load_i > en_i > hold.
- Load: bin_r <= load_val_i, dir_r <= dir_i, wrap_o <= 0. Any en_i in the same cycle is ignored.
- Enabled step: dir_r <= dir_i. bin_r <= bin_r+1 (up) or bin_r-1 (down), mod 2**WIDTH.
  - Wrap up is max -> 0; wrap down is 0 -> max.
  - wrap_o <= 1 only on the edge where a wrap occurs, otherwise 0.
- SATURATE=1: an up step at max or a down step at 0 leaves bin_r unchanged and wrap_o <= 0. dir_r is still updated.
- Hold (en_i=0, load_i=0): all state held; wrap_o <= 0.
- gray(x) = x ^ (x >> 1). count_o changes by exactly one bit per step, wrap included. Loads may change several bits.
- nextCount_o = gray(step(bin_r, dir_r)) after the update, with saturation applied. In SATURATE mode at the terminal value, nextCount_o == count_o.
- tc_o follows the updated bin_r/dir_r, so it is valid in the same cycle as count_o.
- Direction reversal mid-count is legal with no bubble: the step uses dir_i of that cycle.
- Asserting reset mid-operation immediately forces reset values regardless of load_i/en_i.

Decomposition:
- Shared package gray_pkg holds:
  - function bin2gray(x)
  - function gray2bin(g) (for the bench and future users)
  - localparam helper for MAX = 2**WIDTH-1
- Reuse the existing gray_encoder sub-module, two instances: one for the current value, one for the next value. A separate step/saturate unit is not warranted; that logic stays inline.

Test Plan:
1. Reset, WIDTH=4, RESET_VAL=0 -> count_o=0000, nextCount_o=0001, binCount_o=0, tc_o=0, wrap_o=0. Then 16 up steps -> count_o visits every Gray code with 1-bit changes; on the 16th step bin 15->0, count_o 1000->0000, wrap_o pulses one cycle.
2. load_i=1, load_val_i=5, dir_i=1, en_i=1 same cycle -> next cycle binCount_o=5, count_o=0111, nextCount_o=0101; no step taken.
3. From bin 6 (gray 0101), en_i=1, dir_i=0 -> bin 5, count_o=0111, nextCount_o=0110. Continue down to 0 -> tc_o=1. One more step -> bin 15, count_o=1000, wrap_o=1.
4. SATURATE=1, load 15 up, then 3 enabled up steps -> count_o stays 1000, nextCount_o=1000, tc_o=1, wrap_o never asserts. Then one down step -> bin 14, count_o=1001.
5. en_i toggling 1010... for 8 cycles from 0 -> exactly 4 increments; outputs held on disabled cycles.
6. Assert rst_i asynchronously between edges during counting at bin 9 -> outputs reach RESET_VAL values before the next clk_i edge and stay there while rst_i is high; counting resumes from RESET_VAL after release.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and width-derived constants
package gray_pkg;

    function automatic logic [31:0] bin2gray(input logic [31:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [31:0] max_val(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/gray_encoder.sv
// gray_encoder: combinational binary to Gray conversion
module gray_encoder
    import gray_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = WIDTH'(bin2gray(32'(bin)));
endmodule

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: up/down Gray counter with load, wrap/saturate mode and flags
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] nextCount_o,
    output logic [WIDTH-1:0] binCount_o,
    output logic             tc_o,
    output logic             wrap_o
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));

    logic [WIDTH-1:0] bin_r, next_bin;
    logic             dir_r, wrap_r, in_term;

    // terminal test uses the incoming direction so reversal needs no bubble
    assign in_term = dir_i ? (bin_r == MAX) : (bin_r == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_r  <= WIDTH'(RESET_VAL);
            dir_r  <= 1'b1;
            wrap_r <= 1'b0;
        end else if (load_i) begin
            bin_r  <= load_val_i;
            dir_r  <= dir_i;
            wrap_r <= 1'b0;
        end else if (en_i) begin
            dir_r  <= dir_i;
            bin_r  <= (SATURATE && in_term) ? bin_r : dir_i ? bin_r + 1'b1 : bin_r - 1'b1;
            wrap_r <= !SATURATE && in_term;
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign tc_o       = dir_r ? (bin_r == MAX) : (bin_r == '0);
    assign next_bin   = (SATURATE && tc_o) ? bin_r : dir_r ? bin_r + 1'b1 : bin_r - 1'b1;
    assign binCount_o = bin_r;
    assign wrap_o     = wrap_r;

    gray_encoder #(.WIDTH(WIDTH)) u_cur (.bin(bin_r),    .gray(count_o));
    gray_encoder #(.WIDTH(WIDTH)) u_nxt (.bin(next_bin), .gray(nextCount_o));

endmodule
